// File: rtl/tdm_mux4x1_if.sv
// Lane-side and stream-side signals of the 4-to-1 TDM multiplexer.
// slave = the mux, master = the environment driving lanes and sinking output.
interface tdm_mux4x1_if #(
  parameter int WIDTH = 8
);
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_sel,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_sel,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/tdm_mux4x1.sv
// Round-robin 4-to-1 TDM mux with a single registered output word.
// out_sel tags each word with its source lane for a downstream demux.
module tdm_mux4x1 #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  tdm_mux4x1_if.slave    bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       ptr_q, ptr_d;

  logic       load;
  logic       gnt_vld;
  logic [1:0] gnt_idx;
  logic [1:0] idx;

  assign load = !out_valid_q || bus.out_ready;

  // Walk from the farthest lane back to ptr so the closest valid lane wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (bus.in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    bus.in_ready = 4'b0000;
    if (!rst && load && gnt_vld)
      bus.in_ready = 4'b0001 << gnt_idx;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_vld) begin
        out_data_d  = bus.in_data[gnt_idx*WIDTH +: WIDTH];
        out_sel_d   = gnt_idx;
        out_valid_d = 1'b1;
        ptr_d       = gnt_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
      ptr_q       <= 2'd0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/tdm_mux4x1.md
Name:
tdm_mux4x1

Overview:
- Round-robin, time-division 4-to-1 multiplexer. It is the gathering counterpart of the team's 1x4 demultiplexer.
- Four input lanes, each with a valid/ready handshake, are merged into one registered output stream.
- Each output word carries its 2-bit lane tag (out_sel), so a downstream demux1x4 can route the word back by driving its s input from out_sel.

Parameters:
- WIDTH, 8, data bits per lane and on the output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  4*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  4  bit k set = lane k offers a word.
- in_ready  output  4  bit k set = lane k's word is accepted this cycle; at most one bit set.
- out_data  output  WIDTH  registered output word.
- out_sel  output  2  lane index of out_data.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (asynchronous, rst=1):
  - out_valid=0, out_data=0, out_sel=0, internal priority pointer ptr=0.
  - in_ready is forced to 4'b0000 combinationally while rst=1.
  - Reset mid-transfer discards the held word; nothing is replayed.
- Load enable: load = !out_valid || out_ready (combinational).
- Grant:
  - Search lanes in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The grant goes to the first lane with in_valid set.
  - No valid lane means no grant.
- in_ready = one-hot of the granted lane when load=1 and a grant exists; otherwise 4'b0000.
  - in_ready may depend combinationally on in_valid. Upstream must not make in_valid depend on in_ready.
- Transfer on a lane: in_valid[k] & in_ready[k] at a rising edge.
- On a transfer from lane k (next edge):
  - out_data<=lane k data, out_sel<=k, out_valid<=1.
  - ptr<=(k+1) mod 4; 2-bit wrap, so 3 goes to 0.
- load=1 and no grant: out_valid<=0; out_data, out_sel and ptr hold their values.
- load=0 (out_valid=1, out_ready=0): all outputs and ptr hold, and in_ready=0000.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 word per cycle with out_ready=1.
- Simultaneous events:
  - Downstream consumption (out_ready=1) and a new input transfer in the same cycle are legal.
  - The new word replaces the old one at that edge with no bubble.
- Fairness: a continuously valid lane waits at most 3 transfers between grants.
- Data path: lane data is copied bit-exact. No arithmetic and no width change.
- No internal storage beyond the single output register, ptr and out_sel.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert rst between clock edges while out_valid=1, out_data=8'h3C.
  - Required response: out_valid=0, out_data=8'h00, out_sel=0 and in_ready=0000 immediately, without waiting for a clock edge.
  - After rst deasserts, the first grant is searched from lane 0.
- Single lane:
  - Stimulus: in_valid=4'b0100, lane2=8'hA5, out_ready=1.
  - Required response: in_ready=4'b0100 in the same cycle. After the next edge, out_valid=1, out_sel=2, out_data=8'hA5.
- All lanes busy:
  - Stimulus: in_valid=4'b1111 held, lane k data=8'h10+k, out_ready=1.
  - Required response: out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_data 8'h10,8'h11,8'h12,8'h13,8'h10, with no idle cycles.
- Backpressure:
  - Stimulus: with out_valid=1, out_sel=1, out_data=8'h11, hold out_ready=0 for 3 cycles.
  - Required response during the stall: outputs stable, in_ready=0000.
  - Required response when out_ready returns to 1: lane 2 is granted in that same cycle, and out_sel=2 appears at the next edge.
- Wrap and fairness:
  - Stimulus: after serving lane 2 (ptr=3), drive in_valid=4'b0011.
  - Required response: lane 0 is granted, then lane 1. The in_ready sequence is 0001 then 0010.
- Idle drain:
  - Stimulus: in_valid=0000, out_ready=1, with out_valid=1 and out_data=8'h5A.
  - Required response: out_valid=0 at the next edge. out_data stays 8'h5A and out_sel is unchanged.
